ram_burst_ctrl: RTL
===================

Name: ram_burst_ctrl

Overview:
Upstream master for the 256x16 single-port RAM (clk, 8-bit addr, inout 16-bit data, ce/oe/we). It turns a valid/ready burst command into correctly timed ce/oe/we/addr sequences and owns the shared tristate data bus. Writes stream in over a valid/ready channel. Reads stream out at one word per cycle, using the RAM's registered read (1-cycle internal latency, bus driven while ce&oe&!we). Address wraps 255->0.

Parameters:
AW, 8, RAM address width (depth 2^AW)
DW, 16, data width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller idle, command accepted when cmd_valid&cmd_ready
cmd_we  in  1  1=write burst, 0=read burst
cmd_addr  in  AW  start address
cmd_len  in  AW  burst length minus one (0 -> 1 word, 255 -> 256 words)
wr_valid  in  1  write word available
wr_ready  out  1  controller accepts write word
wr_data  in  DW  write word
rd_valid  out  1  read word valid (single-cycle, no backpressure)
rd_data  out  DW  read word
done  out  1  one-cycle pulse, burst complete
ram_addr  out  AW  to RAM addr
ram_data  inout  DW  to RAM data bus
ram_ce  out  1  to RAM ce
ram_oe  out  1  to RAM oe
ram_we  out  1  to RAM we

Behaviour:
- Reset: after the rst edge, state=IDLE, ram_ce/oe/we=0, ram_addr=0, ram_data released (Z), rd_valid=0, rd_data=0, done=0, wr_ready=0, cmd_ready=1. Reset mid-burst aborts the burst immediately: no done pulse, remaining words dropped.
- All RAM-side outputs and rd_valid/rd_data/done are registered. cmd_ready = (state==IDLE). wr_ready = (state==WR).
- ram_data is driven only when the registered drive flag is 1. The drive flag is set only together with ram_we=1 and ram_oe=0. In every other case ram_data is Z.
- States: IDLE, WR, WR_LAST, RD, RD_DRAIN, TURN.
- IDLE: on accept, latch addr and remaining count = cmd_len. cmd_we=1 -> WR. cmd_we=0 -> RD, with ram_ce=ram_oe=1, ram_we=0, ram_addr=cmd_addr in the next cycle.
- WR: at each edge with wr_valid=1:
  - Register ram_addr=cur_addr, ram_wdata=wr_data, ram_ce=ram_we=1, drive=1 for the next cycle. The RAM writes at the following edge.
  - cur_addr increments mod 256 and the count decrements.
  - On the last word go to WR_LAST (wr_ready=0).
- WR stall: an edge with wr_valid=0 registers ram_ce=ram_we=drive=0 (a bubble). No address advance.
- WR_LAST: the final write cycle. At its edge, clear ce/we/drive, pulse done and go to IDLE. Write latency is 2 edges from the data handshake to the RAM write.
- RD (pipelined):
  - Each cycle issue cur_addr with ce=oe=1, then increment.
  - Capture ram_data into rd_data with rd_valid=1 at every edge following a cycle whose issue was preceded by an issue.
  - After issuing the last address go to RD_DRAIN.
- RD_DRAIN: hold ce=oe=1 and the last address for one cycle so the RAM drives the final word. Capture it, then go to TURN with ce=oe=0.
- Read timing: the first rd_valid is seen in the 3rd cycle after the accept edge. rd_valid stays high for cmd_len+1 consecutive cycles. rd_data[i] = mem[(cmd_addr+i) mod 256].
- TURN: one idle cycle for bus turnaround. It pulses done and goes to IDLE. No write may drive the bus within one cycle of the RAM's oe falling.
- Boundaries:
  - Wrap 255->0 inside a burst is silent.
  - cmd_len=255 covers all 256 words, so the start address is revisited only if the burst exceeds 256 words (impossible).
  - cmd_valid while busy is ignored, because cmd_ready=0.
  - ram_we and ram_oe are never both 1.

Decomposition:
- Shared package ram_pkg: AW/DW defaults, state encoding localparams (IDLE..TURN), RAM_DEPTH=256.
- No sub-module required. The tristate driver is a single continuous assignment inside the block.

Test Plan:
- Write burst addr=0x10, len=3, data 0xA000..0xA003, wr_valid always 1 -> RAM 0x10..0x13 hold A000..A003; done pulses once; ram_oe=0 throughout.
- Read burst addr=0x10, len=3 -> rd_valid high 4 consecutive cycles starting 3rd cycle after accept; rd_data A000,A001,A002,A003; done after TURN.
- Write burst addr=0xFE, len=3 with wr_valid toggling 1,0,1,0,... -> words land at FE,FF,00,01; ram_ce=0 in stall cycles; no address skip; readback matches.
- Read burst addr=0x00, len=255 after filling mem[i]=i^0x5555 -> 256 consecutive rd_valid, each word correct; bus never driven by the controller (drive=0) during the read.
- Assert rst in the 2nd cycle of a len=7 read -> next cycle cmd_ready=1, ce/oe=0, rd_valid=0, no done; a new write command is then accepted normally.
- Read immediately followed by a write (cmd_valid held) -> the TURN cycle is present; the controller's drive flag never overlaps any cycle with ram_oe=1.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst controller: default geometry and FSM states.
package ram_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    WR_LAST  = 3'd2,
    RD       = 3'd3,
    RD_DRAIN = 3'd4,
    TURN     = 3'd5
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Burst master for a single-port RAM with a registered read and a shared
// tristate data bus. Accepts one burst command at a time, streams write words
// in over valid/ready and read words out at one per cycle.
module ram_burst_ctrl
  import ram_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data,
  output logic          ram_ce,
  output logic          ram_oe,
  output logic          ram_we
);

  state_t        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;        // next address to issue
  logic [AW-1:0] rem_q, rem_d;        // words still to issue after the current one
  logic          primed_q, primed_d;  // an issue has already happened in this read
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ce_q, ce_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic          drive_q, drive_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          done_q, done_d;

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WR);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign ram_ce    = ce_q;
  assign ram_oe    = oe_q;
  assign ram_we    = we_q;

  // Bus is released unless a write cycle is in progress.
  assign ram_data = drive_q ? wdata_q : {DW{1'bz}};

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    primed_d   = primed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ce_d       = ce_q;
    oe_d       = oe_q;
    we_d       = we_q;
    drive_d    = drive_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        primed_d = 1'b0;
        if (cmd_valid) begin
          rem_d = cmd_len;
          if (cmd_we) begin
            cur_d   = cmd_addr;
            state_d = WR;
          end else begin
            // First read address goes out in the very next cycle.
            addr_d  = cmd_addr;
            cur_d   = cmd_addr + AW'(1);
            ce_d    = 1'b1;
            oe_d    = 1'b1;
            we_d    = 1'b0;
            state_d = RD;
          end
        end
      end

      WR: begin
        if (wr_valid) begin
          addr_d  = cur_q;
          wdata_d = wr_data;
          ce_d    = 1'b1;
          we_d    = 1'b1;
          oe_d    = 1'b0;
          drive_d = 1'b1;
          cur_d   = cur_q + AW'(1);
          if (rem_q == '0) state_d = WR_LAST;
          else             rem_d   = rem_q - AW'(1);
        end else begin
          // Stall: emit a bubble, address stays put.
          ce_d    = 1'b0;
          we_d    = 1'b0;
          drive_d = 1'b0;
        end
      end

      WR_LAST: begin
        ce_d    = 1'b0;
        we_d    = 1'b0;
        drive_d = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      RD: begin
        primed_d = 1'b1;
        // The word of the previous issue is on the bus this cycle.
        if (primed_q) begin
          rd_valid_d = 1'b1;
          rd_data_d  = ram_data;
        end
        if (rem_q == '0) begin
          // Last address already out: hold it one more cycle.
          state_d = RD_DRAIN;
        end else begin
          addr_d = cur_q;
          cur_d  = cur_q + AW'(1);
          rem_d  = rem_q - AW'(1);
        end
      end

      RD_DRAIN: begin
        rd_valid_d = 1'b1;
        rd_data_d  = ram_data;
        ce_d       = 1'b0;
        oe_d       = 1'b0;
        state_d    = TURN;
      end

      TURN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      primed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ce_q       <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      drive_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      primed_q   <= primed_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ce_q       <= ce_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      drive_q    <= drive_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
    end
  end

endmodule
